time_entry: RTL and testbench
=============================

# time_entry

Time-entry controller feeding the clock core's load path, the input-side counterpart of the BCD/seven-segment display chain. It takes a digit from SW[3:0] and three key presses (start/enter/cancel), steps a cursor through H1 H0 M1 M0 S1 S0 and AM/PM, and validates each digit against 12-hour clock limits. It converts the BCD entry to binary hr/min/sec and offers the result to the clock core over a valid/ready load handshake. A parallel BCD copy of the entry drives the display during editing.

## Interface
- DEB_CYCLES, default 500000: consecutive stable synced cycles needed to accept a key press or release (10 ms at 50 MHz).
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  synchronous, active-low reset.
- digit_in  in  4  raw BCD digit from switches; asynchronous.
- start  in  1  raw key, active-high, asynchronous; begins entry.
- enter  in  1  raw key, active-high, asynchronous; commits the current digit.
- cancel  in  1  raw key, active-high, asynchronous; aborts entry.
- load_ready  in  1  clock core accepts the load.
- load_valid  out  1  hr/min/sec/pm hold a complete, validated time.
- hr  out  5  binary hour, 1..12.
- min  out  6  binary minute, 0..59.
- sec  out  6  binary second, 0..59.
- pm  out  1  1 = PM.
- entry_bcd  out  24  {H1,H0,M1,M0,S1,S0} digits entered so far; digits not yet entered are 0.
- edit_pos  out  3  0 idle, 1..6 = H1..S0, 7 = AM/PM.
- err  out  1  one-cycle pulse when an enter is rejected.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Inputs: every raw input passes through a 2-FF synchronizer.
- Keys: each key then has a debouncer. A key event is a one-cycle pulse on the cycle the synced level has been high for DEB_CYCLES consecutive cycles. The key re-arms only after the synced level has been low for DEB_CYCLES consecutive cycles. Each press gives exactly one event.
- Digit value: the digit used is the synced digit_in sampled on the event cycle.
- Event priority: cancel > enter > start.
- FSM states: IDLE, H1, H0, M1, M0, S1, S0, AP, LOAD.
- IDLE: a start event clears entry_bcd and moves to H1. Enter and cancel are ignored.
- Digit states: an enter with a valid digit writes that digit's field in entry_bcd and advances to the next state. An invalid digit sets err for one cycle; state and entry_bcd are unchanged.
- Digit validity rules:
  - H1 must be 0..1.
  - H0 must be 0..2 if H1=1, else 1..9.
  - M1 and S1 must be 0..5.
  - M0 and S0 must be 0..9.
- AP: an enter always succeeds; pm <= digit_in[0], then go to LOAD.
- LOAD: hr, min and sec are computed as d1*10+d0 and registered on entry to LOAD. load_valid is high for every LOAD cycle. On load_valid && load_ready, the transfer completes and the next state is IDLE.
- Cancel: in H1..AP, cancel returns to IDLE, clears entry_bcd, and produces no load. Cancel and start are ignored in LOAD, so valid never drops before the transfer.
- Output stability: hr/min/sec/pm stay unchanged while load_valid is high and keep their last loaded value after the transfer.
- Width rules: hr fits 5 bits and min/sec fit 6 bits by construction; all arithmetic is unsigned.

## Timing
- Reset values: state IDLE, load_valid 0, hr 0, min 0, sec 0, pm 0, entry_bcd 0, edit_pos 0, err 0, busy 0. Debounce counters and synchronizers are cleared.
- Raw key to event pulse: 2 cycles of synchronization plus DEB_CYCLES.
- Event to state change: state, entry_bcd and edit_pos update on the next clock edge.
- err: asserted on the same edge as that state update, for exactly one cycle.
- Enter on S0's last digit: AP is entered on the following edge.
- AP enter to load_valid: load_valid rises on the edge after the AP enter event, together with hr/min/sec.
- Zero-wait transfer: with load_ready held high, load_valid is high for exactly 1 cycle.
- Reset mid-operation: rst low at any edge forces all reset values on that edge, including dropping load_valid.

## Test plan
- DEB_CYCLES=4, load_ready=1: start, then enter digits 1,1,5,9,5,8,1 -> load_valid high for 1 cycle with hr=11, min=59, sec=58, pm=1; entry_bcd=0x115958 during that cycle; busy low afterwards.
- Enter H1=2 -> err pulse, edit_pos stays 1. Then 1, then H0=3 -> err. Then 0 -> edit_pos=3, entry_bcd=0x100000. Also cover H1=0, H0=0 -> err.
- Backpressure: complete entry 01:00:00 AM with load_ready=0 for 10 cycles. Required: load_valid held, hr=1, min=0, sec=0 and pm=0 stable, a cancel press ignored. Then raise load_ready -> transfer completes, IDLE next cycle.
- Cancel at edit_pos=4 -> IDLE next cycle, entry_bcd=0, load_valid never asserted.
- Debounce:
  - An enter glitch of 3 synced-high cycles -> no event.
  - A 20-cycle press -> exactly one event.
  - A second press with only 2 low cycles in between -> no event.
  - enter+cancel in the same cycle -> cancel wins.
- rst low during LOAD with load_ready=0 -> load_valid=0, edit_pos=0 and hr/min/sec=0 on that edge. A subsequent start begins entry at H1.

Source files
------------

// File: rtl/time_entry_if.sv
// time_entry_if
//   Load handshake between the time-entry controller and the clock core.
//   The master offers a complete, validated time on hr/min/sec/pm and holds
//   load_valid until the slave answers with load_ready.
//   Signals:
//     load_valid  master -> slave  time fields hold a validated entry
//     load_ready  slave -> master  clock core accepts the load this cycle
//     hr          master -> slave  binary hour 1..12
//     min         master -> slave  binary minute 0..59
//     sec         master -> slave  binary second 0..59
//     pm          master -> slave  1 = PM
interface time_entry_if;
   logic       load_valid;
   logic       load_ready;
   logic [4:0] hr;
   logic [5:0] min;
   logic [5:0] sec;
   logic       pm;

   modport master (
      output load_valid, hr, min, sec, pm,
      input  load_ready
   );

   modport slave (
      input  load_valid, hr, min, sec, pm,
      output load_ready
   );
endinterface

// File: rtl/time_entry.sv
// time_entry
//   Time-entry controller for a 12-hour clock. A digit on digit_in is
//   committed with the enter key while a cursor walks H1 H0 M1 M0 S1 S0 and
//   AM/PM. Each digit is checked against 12-hour limits; the finished entry
//   is converted to binary and offered to the clock core over the load bus.
//   Ports:
//     clk        system clock
//     rst        synchronous reset, active low
//     digit_in   raw BCD digit from switches (asynchronous)
//     start      raw key, begins an entry (asynchronous)
//     enter      raw key, commits the current digit (asynchronous)
//     cancel     raw key, aborts an entry (asynchronous)
//     load       load handshake towards the clock core (master side)
//     entry_bcd  {H1,H0,M1,M0,S1,S0} digits entered so far
//     edit_pos   0 idle, 1..6 = H1..S0, 7 = AM/PM
//     err        one-cycle pulse when an enter is rejected
//     busy       high whenever the controller is not idle
module time_entry #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         digit_in,
   input  logic               start,
   input  logic               enter,
   input  logic               cancel,
   time_entry_if.master       load,
   output logic [23:0]        entry_bcd,
   output logic [2:0]         edit_pos,
   output logic               err,
   output logic               busy
);

   localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE, H1, H0, M1, M0, S1, S0, AP, LOAD
   } state_t;

   state_t        state, state_next;
   logic [2:0]    key_meta, key_sync;
   logic [3:0]    digit_meta, digit_sync;
   logic [CW-1:0] deb_cnt [3];
   logic [2:0]    armed;
   logic [2:0]    key_ev;
   logic          start_ev, enter_ev, cancel_ev;
   logic [23:0]   entry_next;
   logic          err_next;
   logic          capture;
   logic          digit_ok;
   logic [4:0]    hr_q;
   logic [5:0]    min_q, sec_q;
   logic          pm_q;

   // Two-stage synchronizers; key bit order is {cancel, enter, start}.
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_meta   <= '0;
         key_sync   <= '0;
         digit_meta <= '0;
         digit_sync <= '0;
      end else begin
         key_meta   <= {cancel, enter, start};
         key_sync   <= key_meta;
         digit_meta <= digit_in;
         digit_sync <= digit_meta;
      end
   end

   // Debouncers. An armed key waits for a run of high levels, a disarmed key
   // waits for a run of low levels; any break in the run restarts the count.
   // Reaching the end of a run flips the armed flag, so one press yields one
   // event and the key must be released cleanly before it can fire again.
   always_ff @(posedge clk) begin
      if (!rst) begin
         armed <= '1;
         for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (key_sync[k] != armed[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == LAST) begin
               deb_cnt[k] <= '0;
               armed[k]   <= ~armed[k];
            end else begin
               deb_cnt[k] <= deb_cnt[k] + CW'(1);
            end
         end
      end
   end

   // The event is the last cycle of an armed high run.
   always_comb begin
      key_ev = '0;
      for (int k = 0; k < 3; k++) begin
         key_ev[k] = armed[k] && key_sync[k] && (deb_cnt[k] == LAST);
      end
   end

   assign start_ev  = key_ev[0];
   assign enter_ev  = key_ev[1];
   assign cancel_ev = key_ev[2];

   // Next-state logic. Cancel outranks enter, which outranks start. In LOAD
   // only the handshake can move the state, so valid never drops early.
   always_comb begin
      state_next = state;
      entry_next = entry_bcd;
      err_next   = 1'b0;
      capture    = 1'b0;
      digit_ok   = 1'b0;

      case (state)
         H1:      digit_ok = (digit_sync <= 4'd1);
         H0:      digit_ok = (entry_bcd[23:20] == 4'd1) ? (digit_sync <= 4'd2)
                                                        : (digit_sync >= 4'd1 && digit_sync <= 4'd9);
         M1, S1:  digit_ok = (digit_sync <= 4'd5);
         M0, S0:  digit_ok = (digit_sync <= 4'd9);
         default: digit_ok = 1'b0;
      endcase

      case (state)
         IDLE: begin
            if (start_ev && !enter_ev && !cancel_ev) begin
               entry_next = '0;
               state_next = H1;
            end
         end
         LOAD: begin
            if (load.load_ready) state_next = IDLE;
         end
         default: begin
            if (cancel_ev) begin
               entry_next = '0;
               state_next = IDLE;
            end else if (enter_ev) begin
               if (state == AP) begin
                  capture    = 1'b1;
                  state_next = LOAD;
               end else if (!digit_ok) begin
                  err_next = 1'b1;
               end else begin
                  case (state)
                     H1:      begin entry_next[23:20] = digit_sync; state_next = H0; end
                     H0:      begin entry_next[19:16] = digit_sync; state_next = M1; end
                     M1:      begin entry_next[15:12] = digit_sync; state_next = M0; end
                     M0:      begin entry_next[11:8]  = digit_sync; state_next = S1; end
                     S1:      begin entry_next[7:4]   = digit_sync; state_next = S0; end
                     S0:      begin entry_next[3:0]   = digit_sync; state_next = AP; end
                     default: state_next = state;
                  endcase
               end
            end
         end
      endcase
   end

   // State, entry and error registers. The binary time is captured only on
   // the AP commit, so it holds through LOAD and after the transfer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         entry_bcd <= '0;
         err       <= 1'b0;
         hr_q      <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         pm_q      <= 1'b0;
      end else begin
         state     <= state_next;
         entry_bcd <= entry_next;
         err       <= err_next;
         if (capture) begin
            hr_q  <= 5'(entry_bcd[23:20]) * 5'd10 + 5'(entry_bcd[19:16]);
            min_q <= 6'(entry_bcd[15:12]) * 6'd10 + 6'(entry_bcd[11:8]);
            sec_q <= 6'(entry_bcd[7:4])   * 6'd10 + 6'(entry_bcd[3:0]);
            pm_q  <= digit_sync[0];
         end
      end
   end

   // Cursor position shown to the display; LOAD is not an editing position.
   always_comb begin
      edit_pos = 3'd0;
      case (state)
         H1:      edit_pos = 3'd1;
         H0:      edit_pos = 3'd2;
         M1:      edit_pos = 3'd3;
         M0:      edit_pos = 3'd4;
         S1:      edit_pos = 3'd5;
         S0:      edit_pos = 3'd6;
         AP:      edit_pos = 3'd7;
         default: edit_pos = 3'd0;
      endcase
   end

   assign busy            = (state != IDLE);
   assign load.load_valid = (state == LOAD);
   assign load.hr         = hr_q;
   assign load.min        = min_q;
   assign load.sec        = sec_q;
   assign load.pm         = pm_q;

endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry
//   Self-checking bench for time_entry with a short debounce window.
//   A table of key presses with hand-computed cursor/entry results is
//   applied in a loop; hand-written sequences cover debounce timing,
//   backpressure, simultaneous keys and reset during LOAD.
module tb_time_entry;

   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  digit_in;
   logic        start, enter, cancel;
   logic [23:0] entry_bcd;
   logic [2:0]  edit_pos;
   logic        err, busy;

   time_entry_if bus();

   time_entry #(.DEB_CYCLES(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .digit_in  (digit_in),
      .start     (start),
      .enter     (enter),
      .cancel    (cancel),
      .load      (bus),
      .entry_bcd (entry_bcd),
      .edit_pos  (edit_pos),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Counts of err and load_valid cycles plus the values seen during load.
   int          err_seen   = 0;
   int          valid_seen = 0;
   int          unstable   = 0;
   logic        prev_valid = 1'b0;
   logic [17:0] last_load  = '0;
   logic [4:0]  cap_hr  = '0;
   logic [5:0]  cap_min = '0;
   logic [5:0]  cap_sec = '0;
   logic        cap_pm  = 1'b0;
   logic [23:0] cap_bcd = '0;

   always @(negedge clk) begin
      if (rst) begin
         if (err) err_seen++;
         if (bus.load_valid) begin
            if (prev_valid && ({bus.hr, bus.min, bus.sec, bus.pm} != last_load)) unstable++;
            valid_seen++;
            last_load = {bus.hr, bus.min, bus.sec, bus.pm};
            cap_hr  = bus.hr;
            cap_min = bus.min;
            cap_sec = bus.sec;
            cap_pm  = bus.pm;
            cap_bcd = entry_bcd;
         end
         prev_valid = bus.load_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   typedef struct {
      logic [1:0]  key;
      logic [3:0]  dig;
      logic [2:0]  pos;
      logic [23:0] bcd;
      logic        bsy;
      int          errs;
      int          valids;
   } vec_t;

   vec_t vecs [20];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // key: 0 start, 1 enter, 2 cancel, 3 enter and cancel together
   task automatic applyStimulus(input logic [1:0] key, input logic [3:0] dig);
      digit_in = dig;
      case (key)
         2'd0:    start = 1'b1;
         2'd1:    enter = 1'b1;
         2'd2:    cancel = 1'b1;
         default: begin enter = 1'b1; cancel = 1'b1; end
      endcase
      tick(8);
      start  = 1'b0;
      enter  = 1'b0;
      cancel = 1'b0;
      tick(8);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   initial begin
      int e0, v0;

      vecs[0]  = '{2'd1, 4'd2, 3'd1, 24'h000000, 1'b1, 1, 0};
      vecs[1]  = '{2'd1, 4'd1, 3'd2, 24'h100000, 1'b1, 0, 0};
      vecs[2]  = '{2'd1, 4'd3, 3'd2, 24'h100000, 1'b1, 1, 0};
      vecs[3]  = '{2'd1, 4'd0, 3'd3, 24'h100000, 1'b1, 0, 0};
      vecs[4]  = '{2'd2, 4'd0, 3'd0, 24'h000000, 1'b0, 0, 0};
      vecs[5]  = '{2'd0, 4'd0, 3'd1, 24'h000000, 1'b1, 0, 0};
      vecs[6]  = '{2'd1, 4'd0, 3'd2, 24'h000000, 1'b1, 0, 0};
      vecs[7]  = '{2'd1, 4'd0, 3'd2, 24'h000000, 1'b1, 1, 0};
      vecs[8]  = '{2'd1, 4'd9, 3'd3, 24'h090000, 1'b1, 0, 0};
      vecs[9]  = '{2'd1, 4'd6, 3'd3, 24'h090000, 1'b1, 1, 0};
      vecs[10] = '{2'd1, 4'd5, 3'd4, 24'h095000, 1'b1, 0, 0};
      vecs[11] = '{2'd2, 4'd0, 3'd0, 24'h000000, 1'b0, 0, 0};
      vecs[12] = '{2'd0, 4'd0, 3'd1, 24'h000000, 1'b1, 0, 0};
      vecs[13] = '{2'd1, 4'd1, 3'd2, 24'h100000, 1'b1, 0, 0};
      vecs[14] = '{2'd1, 4'd1, 3'd3, 24'h110000, 1'b1, 0, 0};
      vecs[15] = '{2'd1, 4'd5, 3'd4, 24'h115000, 1'b1, 0, 0};
      vecs[16] = '{2'd1, 4'd9, 3'd5, 24'h115900, 1'b1, 0, 0};
      vecs[17] = '{2'd1, 4'd5, 3'd6, 24'h115950, 1'b1, 0, 0};
      vecs[18] = '{2'd1, 4'd8, 3'd7, 24'h115958, 1'b1, 0, 0};
      vecs[19] = '{2'd1, 4'd1, 3'd0, 24'h115958, 1'b0, 0, 1};

      rst = 1'b0;
      digit_in = 4'd0;
      start = 1'b0;
      enter = 1'b0;
      cancel = 1'b0;
      bus.load_ready = 1'b1;
      tick(3);

      checkOutput("reset load_valid", 32'(bus.load_valid), 0);
      checkOutput("reset hr", 32'(bus.hr), 0);
      checkOutput("reset min", 32'(bus.min), 0);
      checkOutput("reset sec", 32'(bus.sec), 0);
      checkOutput("reset pm", 32'(bus.pm), 0);
      checkOutput("reset entry_bcd", 32'(entry_bcd), 0);
      checkOutput("reset edit_pos", 32'(edit_pos), 0);
      checkOutput("reset err", 32'(err), 0);
      checkOutput("reset busy", 32'(busy), 0);

      rst = 1'b1;
      tick(2);

      // Start key: state changes exactly six edges after the raw press.
      start = 1'b1;
      tick(5);
      checkOutput("start latency pos before", 32'(edit_pos), 0);
      tick(1);
      checkOutput("start latency pos after", 32'(edit_pos), 1);
      tick(2);
      start = 1'b0;
      tick(8);

      for (int i = 0; i < 20; i++) begin
         e0 = err_seen;
         v0 = valid_seen;
         applyStimulus(vecs[i].key, vecs[i].dig);
         checkOutput($sformatf("vec%0d edit_pos", i), 32'(edit_pos), 32'(vecs[i].pos));
         checkOutput($sformatf("vec%0d entry_bcd", i), 32'(entry_bcd), 32'(vecs[i].bcd));
         checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
         checkOutput($sformatf("vec%0d err pulses", i), 32'(err_seen - e0), 32'(vecs[i].errs));
         checkOutput($sformatf("vec%0d valid cycles", i), 32'(valid_seen - v0), 32'(vecs[i].valids));
      end

      checkOutput("load hr", 32'(cap_hr), 11);
      checkOutput("load min", 32'(cap_min), 59);
      checkOutput("load sec", 32'(cap_sec), 58);
      checkOutput("load pm", 32'(cap_pm), 1);
      checkOutput("load entry_bcd", 32'(cap_bcd), 32'h115958);

      // Backpressure: 01:00:00 AM with the clock core not ready.
      bus.load_ready = 1'b0;
      applyStimulus(2'd0, 4'd0);
      applyStimulus(2'd1, 4'd0);
      applyStimulus(2'd1, 4'd1);
      applyStimulus(2'd1, 4'd0);
      applyStimulus(2'd1, 4'd0);
      applyStimulus(2'd1, 4'd0);
      applyStimulus(2'd1, 4'd0);
      applyStimulus(2'd1, 4'd0);
      checkOutput("bp load_valid", 32'(bus.load_valid), 1);
      checkOutput("bp hr", 32'(bus.hr), 1);
      checkOutput("bp min", 32'(bus.min), 0);
      checkOutput("bp sec", 32'(bus.sec), 0);
      checkOutput("bp pm", 32'(bus.pm), 0);
      checkOutput("bp entry_bcd", 32'(entry_bcd), 32'h010000);
      applyStimulus(2'd2, 4'd0);
      checkOutput("bp cancel ignored valid", 32'(bus.load_valid), 1);
      checkOutput("bp cancel ignored busy", 32'(busy), 1);
      checkOutput("bp hr after cancel", 32'(bus.hr), 1);
      checkOutput("bp held cycles", 32'(valid_seen - 1 >= 10), 1);
      checkOutput("bp stable", 32'(unstable), 0);
      bus.load_ready = 1'b1;
      tick(1);
      checkOutput("bp transfer valid", 32'(bus.load_valid), 0);
      checkOutput("bp transfer busy", 32'(busy), 0);
      checkOutput("bp hr kept", 32'(bus.hr), 1);

      // Debounce corner cases at the H1 position.
      applyStimulus(2'd0, 4'd0);
      e0 = err_seen;
      digit_in = 4'd1;
      enter = 1'b1;
      tick(3);
      enter = 1'b0;
      tick(12);
      checkOutput("glitch edit_pos", 32'(edit_pos), 1);
      enter = 1'b1;
      tick(20);
      enter = 1'b0;
      tick(2);
      enter = 1'b1;
      tick(10);
      enter = 1'b0;
      tick(10);
      checkOutput("long press edit_pos", 32'(edit_pos), 2);
      checkOutput("long press entry_bcd", 32'(entry_bcd), 32'h100000);
      checkOutput("debounce err pulses", 32'(err_seen - e0), 0);
      applyStimulus(2'd3, 4'd1);
      checkOutput("enter+cancel edit_pos", 32'(edit_pos), 0);
      checkOutput("enter+cancel entry_bcd", 32'(entry_bcd), 0);
      checkOutput("enter+cancel err pulses", 32'(err_seen - e0), 0);

      // Reset while LOAD is stalled: 12:34:56 PM.
      bus.load_ready = 1'b0;
      applyStimulus(2'd0, 4'd0);
      applyStimulus(2'd1, 4'd1);
      applyStimulus(2'd1, 4'd2);
      applyStimulus(2'd1, 4'd3);
      applyStimulus(2'd1, 4'd4);
      applyStimulus(2'd1, 4'd5);
      applyStimulus(2'd1, 4'd6);
      applyStimulus(2'd1, 4'd1);
      checkOutput("pre-reset load_valid", 32'(bus.load_valid), 1);
      checkOutput("pre-reset hr", 32'(bus.hr), 12);
      checkOutput("pre-reset min", 32'(bus.min), 34);
      checkOutput("pre-reset sec", 32'(bus.sec), 56);
      checkOutput("pre-reset pm", 32'(bus.pm), 1);
      rst = 1'b0;
      tick(1);
      checkOutput("mid reset load_valid", 32'(bus.load_valid), 0);
      checkOutput("mid reset edit_pos", 32'(edit_pos), 0);
      checkOutput("mid reset hr", 32'(bus.hr), 0);
      checkOutput("mid reset min", 32'(bus.min), 0);
      checkOutput("mid reset sec", 32'(bus.sec), 0);
      checkOutput("mid reset pm", 32'(bus.pm), 0);
      checkOutput("mid reset entry_bcd", 32'(entry_bcd), 0);
      checkOutput("mid reset busy", 32'(busy), 0);
      rst = 1'b1;
      tick(2);
      applyStimulus(2'd0, 4'd0);
      checkOutput("restart edit_pos", 32'(edit_pos), 1);
      checkOutput("restart busy", 32'(busy), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
